rom_ctrl_seq_mux: RTL and testbench

Parametrised N-owner, one-way ROM access mux for rom_ctrl, generalising the two-owner checker/bus mux. Ownership passes monotonically from owner 0 (checker) through owner NumOwners-1, each handover signalled by a MuBi4 advance input. Read responses are routed to the issuing owner through a fixed-latency tag pipeline. Any consistency violation raises a sticky fatal alert and blocks further ROM requests.

---
 rtl/rom_ctrl_seq_mux_pkg.sv | 45 ++++
 rtl/rom_ctrl_seq_mux_tag_pipe.sv | 36 +++
 rtl/rom_ctrl_seq_mux.sv | 156 +++++++++++++++
 tb/tb_rom_ctrl_seq_mux.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_seq_mux_pkg.sv
// Shared types and helpers for the sequential N-owner ROM access mux.
package rom_ctrl_seq_mux_pkg;

  // Multi-bit boolean encoding used on the handover inputs.
  typedef logic [3:0] mubi4_t;
  localparam mubi4_t MuBi4True  = 4'h6;
  localparam mubi4_t MuBi4False = 4'h9;

  // Upper bound on the owner count; the owner index type is sized for it so
  // that tags and helpers are independent of the instance parameters.
  localparam int unsigned MaxOwnerW = 4;
  localparam int unsigned MaxOwners = 16;
  localparam int unsigned MaxAdv    = MaxOwners - 1;

  typedef logic [MaxOwnerW-1:0] owner_idx_t;

  // One entry of the read-response routing pipeline.
  typedef struct packed {
    logic       valid;
    owner_idx_t owner;
  } tag_t;

  // Target owner: length of the leading run of strict-True advance signals.
  function automatic owner_idx_t calc_target(input mubi4_t [MaxAdv-1:0] adv,
                                             input int unsigned num_adv);
    owner_idx_t t;
    logic       run;
    t   = '0;
    run = 1'b1;
    for (int unsigned k = 0; k < MaxAdv; k++) begin
      if ((k < num_adv) && run && (adv[k] == MuBi4True)) begin
        t = owner_idx_t'(k + 1);
      end else begin
        run = 1'b0;
      end
    end
    return t;
  endfunction

  // True when the value is neither of the two legal encodings.
  function automatic logic mubi4_invalid(input mubi4_t v);
    return (v != MuBi4True) && (v != MuBi4False);
  endfunction

endpackage

// File: rtl/rom_ctrl_seq_mux_tag_pipe.sv
// Fixed-depth shift register carrying {valid, owner} for each ROM read.
module rom_ctrl_seq_mux_tag_pipe
  import rom_ctrl_seq_mux_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [Depth-1:0] pipe_q;
  tag_t [Depth-1:0] pipe_d;

  // Shift the new tag in at stage 0 and move every stage one step along.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipeline registers; reset drops every in-flight tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[Depth-1];

endmodule

// File: rtl/rom_ctrl_seq_mux.sv
// One-way N-owner ROM access mux: ownership only moves forward, responses
// follow their issuer, and any inconsistency latches a fatal alert.
module rom_ctrl_seq_mux
  import rom_ctrl_seq_mux_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 39,
  parameter int unsigned NumOwners = 3,
  parameter int unsigned RdLat     = 1,
  localparam int unsigned OwnerW   = $clog2(NumOwners)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  mubi4_t [NumOwners-2:0]            adv_i,
  input  logic   [NumOwners-1:0]            own_req_i,
  input  logic   [NumOwners-1:0][AW-1:0]    own_rom_addr_i,
  input  logic   [NumOwners-1:0][AW-1:0]    own_prince_addr_i,
  output logic   [NumOwners-1:0]            own_gnt_o,
  output logic   [NumOwners-1:0]            own_rvalid_o,
  output logic   [NumOwners-1:0][DW-1:0]    own_rdata_o,
  output logic                              rom_req_o,
  output logic   [AW-1:0]                   rom_rom_addr_o,
  output logic   [AW-1:0]                   rom_prince_addr_o,
  input  logic   [DW-1:0]                   rom_scr_rdata_i,
  input  logic   [DW-1:0]                   rom_clr_rdata_i,
  input  logic                              rom_rvalid_i,
  output logic   [OwnerW-1:0]               owner_o,
  output logic                              alert_o
);

  mubi4_t [MaxAdv-1:0] adv_ext;
  owner_idx_t          target_full;
  logic [OwnerW-1:0]   target;
  logic [OwnerW-1:0]   cur;
  logic [OwnerW-1:0]   owner_d, owner_q;
  logic [OwnerW-1:0]   owner_qq_d, owner_qq;
  logic                alert_src, alert_d, alert_q;
  logic                seen_not_true;
  tag_t                tag_in, tag_out;

  // Resolve the current owner: the furthest owner reachable through a
  // contiguous run of True advances, never below the registered owner.
  always_comb begin
    for (int unsigned k = 0; k < MaxAdv; k++) begin
      adv_ext[k] = MuBi4False;
    end
    for (int unsigned k = 0; k < NumOwners - 1; k++) begin
      adv_ext[k] = adv_i[k];
    end
    target_full = calc_target(adv_ext, NumOwners - 1);
    target      = target_full[OwnerW-1:0];
    cur         = (target > owner_q) ? target : owner_q;
  end

  // Forward the current owner's request to the ROM and build its tag.
  always_comb begin
    rom_req_o         = 1'b0;
    rom_rom_addr_o    = '0;
    rom_prince_addr_o = '0;
    for (int unsigned i = 0; i < NumOwners; i++) begin
      if (cur == OwnerW'(i)) begin
        rom_req_o         = own_req_i[i] & ~alert_q;
        rom_rom_addr_o    = own_rom_addr_i[i];
        rom_prince_addr_o = own_prince_addr_i[i];
      end else begin
        rom_req_o         = rom_req_o;
      end
    end
    tag_in.valid = rom_req_o;
    tag_in.owner = rom_req_o ? owner_idx_t'(cur) : '0;
  end

  rom_ctrl_seq_mux_tag_pipe #(
    .Depth (RdLat)
  ) u_tag_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  // Grants, response routing by tag, and the fixed data fan-out (owner 0
  // is the checker and sees scrambled data).
  always_comb begin
    for (int unsigned i = 0; i < NumOwners; i++) begin
      own_gnt_o[i]    = (cur == OwnerW'(i)) & ~alert_q;
      own_rvalid_o[i] = rom_rvalid_i & tag_out.valid &
                        (tag_out.owner == owner_idx_t'(i));
      own_rdata_o[i]  = (i == 0) ? rom_scr_rdata_i : rom_clr_rdata_i;
    end
  end

  // Collect every consistency violation seen this cycle.
  always_comb begin
    alert_src     = 1'b0;
    seen_not_true = 1'b0;
    for (int unsigned k = 0; k < NumOwners - 1; k++) begin
      if (mubi4_invalid(adv_i[k])) begin
        alert_src = 1'b1;
      end else begin
        alert_src = alert_src;
      end
      // Skip: a later advance is not False while an earlier one is not True.
      if (seen_not_true && (adv_i[k] != MuBi4False)) begin
        alert_src = 1'b1;
      end else begin
        alert_src = alert_src;
      end
      if (adv_i[k] != MuBi4True) begin
        seen_not_true = 1'b1;
      end else begin
        seen_not_true = seen_not_true;
      end
      // Revert: an advance already taken is withdrawn.
      if ((int'(owner_q) > int'(k)) && (adv_i[k] != MuBi4True)) begin
        alert_src = 1'b1;
      end else begin
        alert_src = alert_src;
      end
    end
    if (owner_q < owner_qq) begin
      alert_src = 1'b1;
    end else begin
      alert_src = alert_src;
    end
    if (rom_rvalid_i != tag_out.valid) begin
      alert_src = 1'b1;
    end else begin
      alert_src = alert_src;
    end
  end

  // Next-state values for the owner copies and the sticky alert.
  always_comb begin
    owner_d    = cur;
    owner_qq_d = owner_q;
    alert_d    = alert_q | alert_src;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q  <= '0;
      owner_qq <= '0;
      alert_q  <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      owner_qq <= owner_qq_d;
      alert_q  <= alert_d;
    end
  end

  assign owner_o = owner_q;
  assign alert_o = alert_q;

endmodule

// File: tb/tb_rom_ctrl_seq_mux.sv
// Directed bench for rom_ctrl_seq_mux with a ROM model and a response
// scoreboard keyed on owner and arrival cycle.
module tb_rom_ctrl_seq_mux;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 39;
  localparam int unsigned NO = 3;
  localparam int unsigned RdLat = 2;
  localparam logic [3:0] T = 4'h6;
  localparam logic [3:0] F = 4'h9;

  typedef struct {
    int owner;
    int due;
  } sb_t;

  logic                    clk_i;
  logic                    rst_ni;
  logic [NO-2:0][3:0]      adv_i;
  logic [NO-1:0]           own_req_i;
  logic [NO-1:0][AW-1:0]   own_rom_addr_i;
  logic [NO-1:0][AW-1:0]   own_prince_addr_i;
  logic [NO-1:0]           own_gnt_o;
  logic [NO-1:0]           own_rvalid_o;
  logic [NO-1:0][DW-1:0]   own_rdata_o;
  logic                    rom_req_o;
  logic [AW-1:0]           rom_rom_addr_o;
  logic [AW-1:0]           rom_prince_addr_o;
  logic [DW-1:0]           rom_scr_rdata_i;
  logic [DW-1:0]           rom_clr_rdata_i;
  logic                    rom_rvalid_i;
  logic [1:0]              owner_o;
  logic                    alert_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [RdLat-1:0] rom_pipe;
  sb_t sb_q[$];

  rom_ctrl_seq_mux #(
    .AW(AW), .DW(DW), .NumOwners(NO), .RdLat(RdLat)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .adv_i             (adv_i),
    .own_req_i         (own_req_i),
    .own_rom_addr_i    (own_rom_addr_i),
    .own_prince_addr_i (own_prince_addr_i),
    .own_gnt_o         (own_gnt_o),
    .own_rvalid_o      (own_rvalid_o),
    .own_rdata_o       (own_rdata_o),
    .rom_req_o         (rom_req_o),
    .rom_rom_addr_o    (rom_rom_addr_o),
    .rom_prince_addr_o (rom_prince_addr_o),
    .rom_scr_rdata_i   (rom_scr_rdata_i),
    .rom_clr_rdata_i   (rom_clr_rdata_i),
    .rom_rvalid_i      (rom_rvalid_i),
    .owner_o           (owner_o),
    .alert_o           (alert_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare routed responses against the scoreboard and the data fan-out.
  task automatic sb_check();
    logic [NO-1:0] exp_rv;
    logic [DW-1:0] exp_data;
    int o;
    exp_rv = '0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      o = sb_q[0].owner;
      exp_rv[o] = 1'b1;
      exp_data = (o == 0) ? rom_scr_rdata_i : rom_clr_rdata_i;
      chk("resp_rdata", 64'(own_rdata_o[o]), 64'(exp_data));
      void'(sb_q.pop_front());
    end
    chk("rvalid", 64'(own_rvalid_o), 64'(exp_rv));
    chk("rdata_scr", 64'(own_rdata_o[0]), 64'(rom_scr_rdata_i));
    chk("rdata_clr", 64'(own_rdata_o[2]), 64'(rom_clr_rdata_i));
  endtask

  // Advance one clock; the ROM model answers RdLat cycles after a request.
  task automatic tick();
    logic req_now;
    req_now = rom_req_o;
    @(posedge clk_i);
    #1;
    for (int i = RdLat - 1; i > 0; i--) rom_pipe[i] = rom_pipe[i-1];
    rom_pipe[0] = req_now;
    rom_rvalid_i = rom_pipe[RdLat-1];
    rom_scr_rdata_i = 39'({$urandom(), $urandom()});
    rom_clr_rdata_i = 39'({$urandom(), $urandom()});
    cyc++;
  endtask

  // Close out a cycle, optionally recording an accepted request.
  task automatic fin(input bit push, input int owner);
    sb_t e;
    sb_check();
    if (push) begin
      e.owner = owner;
      e.due = cyc + RdLat;
      sb_q.push_back(e);
    end
    tick();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    adv_i = {F, F};
    own_req_i = '0;
    own_rom_addr_i = '0;
    own_prince_addr_i = '0;
    rom_rvalid_i = 1'b0;
    rom_pipe = '0;
    sb_q.delete();
    @(negedge clk_i);
    chk("rst_owner", 64'(owner_o), 64'd0);
    chk("rst_alert", 64'(alert_o), 64'd0);
    chk("rst_gnt", 64'(own_gnt_o), 64'b001);
    chk("rst_rvalid", 64'(own_rvalid_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rom_scr_rdata_i = 39'h12_3456_789A;
    rom_clr_rdata_i = 39'h05_4321_ABCD;
    do_reset();

    // Owner 0 read.
    own_req_i = 3'b001;
    own_rom_addr_i[0] = 8'h10;
    own_prince_addr_i[0] = 8'h90;
    @(negedge clk_i);
    chk("t1_gnt", 64'(own_gnt_o), 64'b001);
    chk("t1_req", 64'(rom_req_o), 64'd1);
    chk("t1_addr", 64'(rom_rom_addr_o), 64'h10);
    chk("t1_paddr", 64'(rom_prince_addr_o), 64'h90);
    fin(1'b1, 0);
    own_req_i = 3'b000;
    repeat (3) begin
      @(negedge clk_i);
      chk("t1_alert", 64'(alert_o), 64'd0);
      fin(1'b0, 0);
    end

    // Handover to owner 1 with owner 0's read in flight.
    own_req_i = 3'b001;
    own_rom_addr_i[0] = 8'h20;
    @(negedge clk_i);
    fin(1'b1, 0);
    adv_i[0] = T;
    own_req_i = 3'b010;
    own_rom_addr_i[1] = 8'h30;
    own_prince_addr_i[1] = 8'hB0;
    @(negedge clk_i);
    chk("t2_gnt", 64'(own_gnt_o), 64'b010);
    chk("t2_addr", 64'(rom_rom_addr_o), 64'h30);
    chk("t2_paddr", 64'(rom_prince_addr_o), 64'hB0);
    chk("t2_owner_pre", 64'(owner_o), 64'd0);
    fin(1'b1, 1);
    own_req_i = 3'b000;
    @(negedge clk_i);
    chk("t2_owner", 64'(owner_o), 64'd1);
    fin(1'b0, 0);
    repeat (2) begin
      @(negedge clk_i);
      chk("t2_alert", 64'(alert_o), 64'd0);
      fin(1'b0, 0);
    end

    // Double-step handover 0 -> 2.
    do_reset();
    adv_i = {T, T};
    own_req_i = 3'b100;
    own_rom_addr_i[2] = 8'h55;
    @(negedge clk_i);
    chk("t3_gnt", 64'(own_gnt_o), 64'b100);
    chk("t3_addr", 64'(rom_rom_addr_o), 64'h55);
    chk("t3_owner_pre", 64'(owner_o), 64'd0);
    fin(1'b1, 2);
    own_req_i = 3'b000;
    @(negedge clk_i);
    chk("t3_owner", 64'(owner_o), 64'd2);
    fin(1'b0, 0);
    repeat (2) begin
      @(negedge clk_i);
      chk("t3_alert", 64'(alert_o), 64'd0);
      fin(1'b0, 0);
    end

    // Revert of adv_i[1] while owner 2 holds the ROM.
    adv_i[1] = F;
    @(negedge clk_i);
    chk("t4_alert_pre", 64'(alert_o), 64'd0);
    chk("t4_gnt_pre", 64'(own_gnt_o), 64'b100);
    fin(1'b0, 0);
    adv_i[1] = T;
    own_req_i = 3'b100;
    repeat (2) begin
      @(negedge clk_i);
      chk("t4_alert", 64'(alert_o), 64'd1);
      chk("t4_gnt", 64'(own_gnt_o), 64'b000);
      chk("t4_req", 64'(rom_req_o), 64'd0);
      fin(1'b0, 0);
    end

    // Invalid encoding on adv_i[0].
    do_reset();
    adv_i[0] = 4'b0000;
    @(negedge clk_i);
    chk("t5a_alert_pre", 64'(alert_o), 64'd0);
    fin(1'b0, 0);
    adv_i[0] = F;
    @(negedge clk_i);
    chk("t5a_alert", 64'(alert_o), 64'd1);
    fin(1'b0, 0);

    // Skip: adv_i[1] True with adv_i[0] False.
    do_reset();
    adv_i[1] = T;
    adv_i[0] = F;
    @(negedge clk_i);
    chk("t5b_gnt", 64'(own_gnt_o), 64'b001);
    chk("t5b_alert_pre", 64'(alert_o), 64'd0);
    fin(1'b0, 0);
    adv_i[1] = F;
    @(negedge clk_i);
    chk("t5b_alert", 64'(alert_o), 64'd1);
    fin(1'b0, 0);

    // Unexpected response with no tag outstanding, then reset mid-stream.
    do_reset();
    rom_rvalid_i = 1'b1;
    @(negedge clk_i);
    chk("t6_rvalid", 64'(own_rvalid_o), 64'd0);
    fin(1'b0, 0);
    @(negedge clk_i);
    chk("t6_alert", 64'(alert_o), 64'd1);
    fin(1'b0, 0);
    own_req_i = 3'b001;
    do_reset();

    // Reset with a read in flight: the tag must be dropped.
    own_req_i = 3'b001;
    own_rom_addr_i[0] = 8'h44;
    @(negedge clk_i);
    fin(1'b1, 0);
    do_reset();
    repeat (3) begin
      @(negedge clk_i);
      chk("t7_alert", 64'(alert_o), 64'd0);
      fin(1'b0, 0);
    end

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
